// File: rtl/station_sched.sv
// Issue scheduler for two reservation stations sharing one execute port.
// Latency: combinational ack in the grant cycle; issue bus and ld_addr registered one cycle later.
// Backpressure: ex_stall suppresses any grant; ungranted stations hold req until acked.
module station_sched #(
    parameter int WB_LAT = 2,
    parameter int LD_MAX = 3
) (
    input  logic        clk,
    input  logic        a_rst_n,
    input  logic        st0_req,
    input  logic [35:0] st0_uop,
    input  logic [10:0] st0_lock,
    output logic        st0_ack,
    output logic        st0_ld_addr,
    input  logic        st1_req,
    input  logic [35:0] st1_uop,
    input  logic [10:0] st1_lock,
    output logic        st1_ack,
    output logic        st1_ld_addr,
    input  logic        ex_stall,
    input  logic        lsu_wb,
    output logic        iss_valid,
    output logic        iss_sel,
    output logic [35:0] iss_uop,
    output logic [2:0]  ld_cnt
);

    logic [7:0][1:0] sb_q, sb_d;
    logic            fav_q, fav_d;
    logic            iss_valid_q, iss_valid_d;
    logic            iss_sel_q, iss_sel_d;
    logic [35:0]     iss_uop_q, iss_uop_d;
    logic [1:0]      ld_addr_q, ld_addr_d;
    logic [2:0]      ld_cnt_q, ld_cnt_d;

    logic [7:0]  busy;
    logic [35:0] uop [2];
    logic [10:0] lock [2];
    logic [1:0]  req, elig, blk;
    logic        gnt_vld, gnt_sel, gnt_ld, ld_dec;
    logic [35:0] gnt_uop;

    assign req     = {st1_req, st0_req};
    assign uop[0]  = st0_uop;
    assign uop[1]  = st1_uop;
    assign lock[0] = st0_lock;
    assign lock[1] = st1_lock;

    always_comb begin
        busy = '0;
        for (int r = 0; r < 8; r++) begin
            busy[r] = |sb_q[r];
        end
    end

    // blk[g] is only consulted when g is not favoured, so the other station is the favoured one
    for (genvar g = 0; g < 2; g++) begin : g_st
        logic [2:0]  a, b, dr;
        logic        dw, ld, byp;
        logic [10:0] ol;

        assign a   = uop[g][19:17];
        assign b   = uop[g][16:14];
        assign dw  = uop[g][13];
        assign dr  = uop[g][12:10];
        assign ld  = uop[g][2];
        assign byp = uop[g][0];
        assign ol  = lock[g ^ 1];

        assign elig[g] = req[g] & ~ex_stall & ~busy[a] & (byp | ~busy[b])
                       & (~dw | ~busy[dr]) & (~ld | (ld_cnt_q < 3'(LD_MAX)));
        assign blk[g]  = req[g ^ 1] & ((ld & ol[10])
                       | (dw & ((dr == ol[5:3]) | (dr == ol[2:0])))
                       | (ol[9] & ((a == ol[8:6]) | (~byp & (b == ol[8:6])))));
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = fav_q;
        if (elig[fav_q]) begin
            gnt_vld = 1'b1;
        end else if (elig[~fav_q] && !blk[~fav_q]) begin
            gnt_vld = 1'b1;
            gnt_sel = ~fav_q;
        end
    end

    assign gnt_uop = gnt_sel ? uop[1] : uop[0];
    assign gnt_ld  = gnt_vld & gnt_uop[2];
    assign ld_dec  = lsu_wb & (ld_cnt_q != 3'd0);
    assign st0_ack = a_rst_n & gnt_vld & ~gnt_sel;
    assign st1_ack = a_rst_n & gnt_vld & gnt_sel;

    always_comb begin
        for (int r = 0; r < 8; r++) begin
            sb_d[r] = sb_q[r];
            if (gnt_vld && gnt_uop[13] && (gnt_uop[12:10] == 3'(r))) begin
                sb_d[r] = 2'(WB_LAT);
            end else if (busy[r]) begin
                sb_d[r] = sb_q[r] - 2'd1;
            end
        end
        fav_d       = gnt_vld ? ~gnt_sel : fav_q;
        iss_valid_d = gnt_vld;
        iss_sel_d   = gnt_vld ? gnt_sel : iss_sel_q;
        iss_uop_d   = gnt_vld ? gnt_uop : iss_uop_q;
        ld_addr_d   = {gnt_ld & gnt_sel, gnt_ld & ~gnt_sel};
        ld_cnt_d    = ld_cnt_q;
        if (gnt_ld && !ld_dec) begin
            ld_cnt_d = ld_cnt_q + 3'd1;
        end else if (!gnt_ld && ld_dec) begin
            ld_cnt_d = ld_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            sb_q        <= '0;
            fav_q       <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_sel_q   <= 1'b0;
            iss_uop_q   <= '0;
            ld_addr_q   <= '0;
            ld_cnt_q    <= '0;
        end else begin
            sb_q        <= sb_d;
            fav_q       <= fav_d;
            iss_valid_q <= iss_valid_d;
            iss_sel_q   <= iss_sel_d;
            iss_uop_q   <= iss_uop_d;
            ld_addr_q   <= ld_addr_d;
            ld_cnt_q    <= ld_cnt_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_sel     = iss_sel_q;
    assign iss_uop     = iss_uop_q;
    assign ld_cnt      = ld_cnt_q;
    assign st0_ld_addr = ld_addr_q[0];
    assign st1_ld_addr = ld_addr_q[1];

endmodule

// File: tb/tb_station_sched.sv
// Scoreboard bench for station_sched: a time-based reference model predicts acks and
// queues expected issues; a separate monitor pops them when the issue bus goes valid.
module tb_station_sched;

    localparam int WB_LAT = 2;
    localparam int LD_MAX = 3;

    typedef struct packed {
        logic [15:0] k;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [3:0]  d;
        logic [3:0]  fn;
        logic        mc, sf, st, ld, mw, byp;
    } uop_t;

    typedef struct packed {
        logic       loads;
        logic [3:0] wr;
        logic [2:0] rd0;
        logic [2:0] rd1;
    } lock_t;

    typedef struct {
        bit          sel;
        logic [35:0] uop;
        bit          ld;
    } exp_t;

    logic        clk = 1'b0;
    logic        a_rst_n = 1'b0;
    logic        st0_req = 1'b0, st1_req = 1'b0;
    logic [35:0] st0_uop = '0, st1_uop = '0;
    logic [10:0] st0_lock = '0, st1_lock = '0;
    logic        st0_ack, st1_ack, st0_ld_addr, st1_ld_addr;
    logic        ex_stall = 1'b0, lsu_wb = 1'b0;
    logic        iss_valid, iss_sel;
    logic [35:0] iss_uop;
    logic [2:0]  ld_cnt;

    station_sched #(.WB_LAT(WB_LAT), .LD_MAX(LD_MAX)) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .st0_req(st0_req), .st0_uop(st0_uop), .st0_lock(st0_lock),
        .st0_ack(st0_ack), .st0_ld_addr(st0_ld_addr),
        .st1_req(st1_req), .st1_uop(st1_uop), .st1_lock(st1_lock),
        .st1_ack(st1_ack), .st1_ld_addr(st1_ld_addr),
        .ex_stall(ex_stall), .lsu_wb(lsu_wb),
        .iss_valid(iss_valid), .iss_sel(iss_sel), .iss_uop(iss_uop), .ld_cnt(ld_cnt)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ready_at [8];
    int   m_ld = 0;
    int   m_fav = 0;
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    function automatic logic [35:0] mk(input int a, input int b, input bit dw, input int d,
                                       input bit ld, input bit byp);
        uop_t u;
        u     = uop_t'({$urandom, $urandom});
        u.a   = 3'(a);
        u.b   = 3'(b);
        u.d   = {dw, 3'(d)};
        u.ld  = ld;
        u.byp = byp;
        return u;
    endfunction

    function automatic bit m_busy(input logic [2:0] r);
        return cyc < ready_at[r];
    endfunction

    function automatic bit m_elig(input bit rq, input uop_t u);
        if (!rq || ex_stall) return 0;
        if (m_busy(u.a)) return 0;
        if (!u.byp && m_busy(u.b)) return 0;
        if (u.d[3] && m_busy(u.d[2:0])) return 0;
        if (u.ld && m_ld >= LD_MAX) return 0;
        return 1;
    endfunction

    function automatic void model_reset();
        foreach (ready_at[r]) ready_at[r] = 0;
        m_ld  = 0;
        m_fav = 0;
        exp_q.delete();
    endfunction

    // one clock cycle: predict the grant from the current inputs, compare acks, advance the model
    task automatic step(output logic [1:0] acks);
        uop_t  u [2];
        lock_t fl;
        bit    rq [2];
        bit    el [2];
        bit    blocked, inc, dec;
        int    oth, w;
        @(negedge clk);
        u[0] = st0_uop;  u[1] = st1_uop;
        rq[0] = st0_req; rq[1] = st1_req;
        fl   = (m_fav == 0) ? lock_t'(st0_lock) : lock_t'(st1_lock);
        oth  = 1 - m_fav;
        el[0] = m_elig(rq[0], u[0]);
        el[1] = m_elig(rq[1], u[1]);
        blocked = rq[m_fav] && ((u[oth].ld && fl.loads)
                  || (u[oth].d[3] && (u[oth].d[2:0] == fl.rd0 || u[oth].d[2:0] == fl.rd1))
                  || (fl.wr[3] && (u[oth].a == fl.wr[2:0] || (!u[oth].byp && u[oth].b == fl.wr[2:0]))));
        w = -1;
        if (el[m_fav]) w = m_fav;
        else if (el[oth] && !blocked) w = oth;
        acks = {st1_ack, st0_ack};
        chk("ack0", 64'(st0_ack), 64'(w == 0));
        chk("ack1", 64'(st1_ack), 64'(w == 1));
        inc = (w >= 0) && u[w].ld;
        dec = lsu_wb && (m_ld > 0);
        if (w >= 0) begin
            exp_q.push_back('{sel: w[0], uop: u[w], ld: u[w].ld});
            if (u[w].d[3]) ready_at[u[w].d[2:0]] = cyc + WB_LAT + 1;
            m_fav = 1 - w;
        end
        m_ld = m_ld + int'(inc) - int'(dec);
        @(posedge clk);
        cyc++;
        #1;
        chk("ld_cnt", 64'(ld_cnt), 64'(m_ld));
    endtask

    task automatic wait_ack(input int s, input int maxc, output int n);
        logic [1:0] acks;
        n = maxc + 1;
        for (int i = 1; i <= maxc; i++) begin
            step(acks);
            if (acks[s]) begin
                n = i;
                break;
            end
        end
    endtask

    // monitor: issue bus reflects the grant queued at the previous negedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!a_rst_n) continue;
            if (iss_valid) begin
                if (exp_q.size() == 0) begin
                    chk("iss_unexpected", 64'(iss_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("iss_sel", 64'(iss_sel), 64'(e.sel));
                    chk("iss_uop", 64'(iss_uop), 64'(e.uop));
                    chk("ld_addr0", 64'(st0_ld_addr), 64'(e.ld && !e.sel));
                    chk("ld_addr1", 64'(st1_ld_addr), 64'(e.ld && e.sel));
                end
            end else begin
                chk("iss_missing", 64'(exp_q.size()), 64'd0);
                chk("ld_addr_idle", 64'({st1_ld_addr, st0_ld_addr}), 64'd0);
            end
        end
    end

    initial begin
        logic [1:0] acks;
        int         n;
        bit         pend [2];
        model_reset();

        // reset state with an eligible request present
        st0_req = 1'b1;
        st0_uop = mk(1, 2, 1, 3, 0, 0);
        #12;
        chk("rst_ack", 64'({st1_ack, st0_ack}), 64'd0);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_sel", 64'(iss_sel), 64'd0);
        chk("rst_iss_uop", 64'(iss_uop), 64'd0);
        chk("rst_ld_cnt", 64'(ld_cnt), 64'd0);
        chk("rst_ld_addr", 64'({st1_ld_addr, st0_ld_addr}), 64'd0);
        @(posedge clk);
        #1 a_rst_n = 1'b1;

        // write r3, then a reader of r3 waits out WB_LAT
        step(acks);
        chk("first_ack", 64'(acks), 64'b01);
        st0_req = 1'b0;
        st1_req = 1'b1;
        st1_uop = mk(3, 0, 0, 0, 0, 0);
        wait_ack(1, 8, n);
        chk("raw_wait_cycles", 64'(n), 64'd3);
        st1_req = 1'b0;

        // bypassed b operand does not wait
        st0_req = 1'b1;
        st0_uop = mk(1, 2, 1, 3, 0, 0);
        step(acks);
        st0_req = 1'b0;
        st1_req = 1'b1;
        st1_uop = mk(0, 3, 0, 0, 0, 1);
        wait_ack(1, 8, n);
        chk("bypass_wait_cycles", 64'(n), 64'd1);
        st1_req = 1'b0;

        // both ready and hazard-free: grants alternate starting from st0
        st0_req = 1'b1; st0_uop = mk(1, 2, 0, 0, 0, 0);
        st1_req = 1'b1; st1_uop = mk(4, 5, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(acks);
            chk("alternate", 64'(acks), (i % 2 == 0) ? 64'b01 : 64'b10);
        end
        st1_req = 1'b0;

        // load credits
        st0_uop = mk(0, 0, 0, 0, 1, 0);
        repeat (3) step(acks);
        chk("ld_full", 64'(ld_cnt), 64'd3);
        step(acks);
        chk("ld_blocked", 64'(acks), 64'd0);
        lsu_wb = 1'b1;
        step(acks);
        chk("ld_wb_same_cycle", 64'(acks), 64'd0);
        lsu_wb = 1'b0;
        step(acks);
        chk("ld_after_wb", 64'(acks), 64'b01);
        st0_req = 1'b0;
        lsu_wb  = 1'b1;
        repeat (4) step(acks);
        chk("ld_saturate", 64'(ld_cnt), 64'd0);
        lsu_wb = 1'b0;

        // lock_loads from favoured st0 holds st1's load until st0 is granted
        st1_req = 1'b1; st1_uop = mk(0, 0, 1, 5, 0, 0);
        step(acks);
        st0_req = 1'b1; st0_uop = mk(5, 0, 0, 0, 0, 0); st0_lock = 11'h400;
        st1_uop = mk(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(acks);
            chk("lock_seq", 64'(acks), (i < 2) ? 64'd0 : ((i == 2) ? 64'b01 : 64'b10));
            if (acks[0]) st0_req = 1'b0;
        end
        st1_req = 1'b0;
        st0_lock = '0;

        // scoreboard keeps counting down under ex_stall
        st0_req = 1'b1; st0_uop = mk(0, 0, 1, 6, 0, 0);
        step(acks);
        st0_uop = mk(1, 2, 0, 0, 1, 0);
        st1_req = 1'b1; st1_uop = mk(6, 0, 0, 0, 0, 0);
        ex_stall = 1'b1;
        repeat (3) begin
            step(acks);
            chk("stall_noack", 64'(acks), 64'd0);
        end
        ex_stall = 1'b0;
        step(acks);
        chk("stall_countdown", 64'(acks), 64'b10);
        st1_req = 1'b0;
        step(acks);

        // asynchronous reset mid-stream
        a_rst_n = 1'b0;
        #1;
        chk("midrst_ack", 64'({st1_ack, st0_ack}), 64'd0);
        chk("midrst_iss_valid", 64'(iss_valid), 64'd0);
        chk("midrst_ld_cnt", 64'(ld_cnt), 64'd0);
        chk("midrst_ld_addr", 64'({st1_ld_addr, st0_ld_addr}), 64'd0);
        model_reset();
        @(posedge clk);
        #1 a_rst_n = 1'b1;

        // randomized traffic; stations hold each uop until acked
        st0_req = 1'b0; st1_req = 1'b0;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pend[s] && $urandom_range(0, 9) < 6) begin
                    logic [35:0] nu;
                    logic [10:0] nl;
                    nu = mk($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                            $urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3);
                    nl = {$urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
                    pend[s] = 1;
                    if (s == 0) begin st0_uop = nu; st0_lock = nl; end
                    else begin st1_uop = nu; st1_lock = nl; end
                end
            end
            st0_req  = pend[0];
            st1_req  = pend[1];
            ex_stall = $urandom_range(0, 9) < 2;
            lsu_wb   = (m_ld > 0) && ($urandom_range(0, 9) < 3);
            step(acks);
            if (acks[0]) pend[0] = 0;
            if (acks[1]) pend[1] = 0;
        end

        st0_req = 1'b0; st1_req = 1'b0; ex_stall = 1'b0; lsu_wb = 1'b0;
        repeat (3) step(acks);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/station_sched.md
Name: station_sched

Overview:
- Issue scheduler shared by two reservation stations (st0, st1) feeding the single ALU/LSU execute port.
- Each cycle it picks at most one ready uop and returns a combinational sched_ack to the winner.
- The chosen uop is registered onto the issue bus.
- It tracks register write hazards with a latency scoreboard, enforces inter-station lock fields, limits outstanding loads, and tells the issuing station when to latch the ALU-computed address.

Parameters:
WB_LAT, 2, cycles from issue until an ALU register write is visible (1..3).
LD_MAX, 3, maximum loads issued and not yet written back (1..7).

Ports:
clk  in  1  clock, all state on rising edge
a_rst_n  in  1  asynchronous active-low reset
st0_req  in  1  st0 presents a schedulable uop (load/ALU/store step)
st0_uop  in  36  {k16[35:20], a[19:17], b[16:14], d[13:10], fn[9:6], mask_carry[5], save_flags[4], st_mem[3], ld_mem[2], mem_width[1], bypass_b[0]}
st0_lock  in  11  {lock_loads[10], lock_reg_wr[9:6], lock_reg_rd_0[5:3], lock_reg_rd_1[2:0]}
st0_ack  out  1  sched_ack to st0, combinational
st0_ld_addr  out  1  sched_ld_addr to st0
st1_req, st1_uop, st1_lock, st1_ack, st1_ld_addr  as st0 for station 1
ex_stall  in  1  execute port cannot accept; no grant this cycle
lsu_wb  in  1  one outstanding load completed
iss_valid  out  1  issue bus holds a new uop this cycle
iss_sel  out  1  station that issued iss_uop
iss_uop  out  36  registered copy of the granted uop
ld_cnt  out  3  outstanding load count

Behaviour:
- Reset, asynchronous on a_rst_n low:
  - iss_valid=0, iss_sel=0, iss_uop=0, ld_cnt=0.
  - st*_ld_addr=0; all scoreboard counters 0; favoured pointer fav=0.
  - Acks are forced 0 while reset is asserted.
  - Reset mid-operation discards in-flight scoreboard/load state; stations are reset by the same a_rst_n.
- Scoreboard: one 2-bit down counter per register 0..7; register is busy when its counter is nonzero.
  - On issue with d[3]=1, counter[d[2:0]] <= WB_LAT.
  - Otherwise each nonzero counter decrements every cycle, including under ex_stall.
- Eligibility of station s (all conditions required):
  - req_s=1 and ex_stall=0.
  - a not busy.
  - b not busy, or bypass_b=1.
  - If d[3]=1, d[2:0] not busy (WAW).
  - If ld_mem=1, ld_cnt<LD_MAX. The check uses the registered ld_cnt; a same-cycle lsu_wb does not free a credit.
- Lock rules apply only to the non-favoured station, and only while the favoured station's req=1:
  - Blocked if its ld_mem=1 and the favoured station's lock_loads=1.
  - Blocked if its d[3]=1 and d[2:0] equals the favoured station's lock_reg_rd_0 or lock_reg_rd_1 (WAR).
  - Blocked if its a, or its b when bypass_b=0, equals the favoured station's lock_reg_wr[2:0] with lock_reg_wr[3]=1 (RAW).
  - The favoured station is never blocked by locks.
- Grant:
  - If the favoured station is eligible, it wins; else the other wins if eligible; else no grant.
  - Exactly one st*_ack is high for the winner in the same cycle.
  - After a grant to station s, fav <= ~s. With no grant, fav holds.
- Issue register, next edge after a grant:
  - iss_valid=1, iss_sel=s, iss_uop=winner's uop.
  - With no grant: iss_valid=0 and iss_uop holds its value.
- Address latch: st_s_ld_addr=1 exactly one cycle after a grant to s with ld_mem=1, i.e. concurrent with iss_valid for that uop. Otherwise 0.
- ld_cnt update:
  - +1 on a grant with ld_mem=1; -1 on lsu_wb.
  - Both in the same cycle: unchanged.
  - lsu_wb when ld_cnt=0: ignored, count saturates at 0.
- Both stations requesting the same busy register: neither is granted until the counter expires. Requests are level-based; a station keeps req high until acked.

Test Plan:
- Reset release, st0_req=1 with an ALU uop (a=1,b=2,d=4'b1011) -> st0_ack=1 in cycle 0; cycle 1 iss_valid=1, iss_sel=0; fav=1; reg 3 busy 2 cycles.
- Next cycle, st1 reads a=3 -> st1_ack=0 for 2 cycles, ack in the 3rd cycle (WB_LAT=2). Repeat with bypass_b=1 and b=3 only -> granted immediately.
- Both stations ready and hazard-free for 4 cycles -> grants alternate 0,1,0,1; no double ack in any cycle.
- Issue 3 loads (ld_mem=1) with no lsu_wb -> ld_cnt=3, 4th load not acked. Pulse lsu_wb -> ld_cnt=2, load acked next cycle. st_s_ld_addr pulses one cycle after each load ack.
- fav=0 with st0 lock_loads=1, st1 presenting a load -> st1 blocked until st0 is granted. Then fav=1 and st1 is acked.
- ex_stall=1 for 3 cycles with both requesting -> no acks, iss_valid=0, scoreboard still counts down. Assert a_rst_n=0 mid-stream -> ld_cnt, iss_valid and acks 0 immediately.
